// File: rtl/high_pass_filter.sv
// Boxcar high-pass: data_o = x - mean(last DEPTH samples), recursive running sum
// over a circular history buffer held in single-port block RAM.
module high_pass_filter #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     sample_tick_i,
  input  logic                     enable_i,
  input  logic signed [DWIDTH-1:0] data_i,
  output logic signed [DWIDTH-1:0] data_o,
  output logic                     valid_o,
  output logic                     ready_o,
  output logic                     overrun_o
);

  localparam int SH = $clog2(DEPTH);
  localparam int AW = DWIDTH + SH;

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_READ, S_UPDATE, S_OUT} state_t;

  state_t state_reg, state_next;

  logic [SH-1:0]            clr_ptr_reg;
  logic [SH-1:0]            wptr_reg;
  logic signed [AW-1:0]     acc_reg;
  logic signed [AW-1:0]     acc_next;
  logic signed [DWIDTH-1:0] x_reg;
  logic signed [DWIDTH-1:0] sat_reg;
  logic signed [DWIDTH-1:0] data_reg;
  logic                     pend_reg;
  logic                     valid_reg;
  logic                     ready_reg;
  logic                     overrun_reg;

  logic signed [DWIDTH-1:0] mem [DEPTH];
  logic signed [DWIDTH-1:0] ram_q_reg;
  logic                     ram_we;
  logic [SH-1:0]            ram_addr;
  logic signed [DWIDTH-1:0] ram_wdata;

  logic signed [DWIDTH-1:0] mean;
  logic signed [DWIDTH:0]   hp;
  logic signed [DWIDTH-1:0] hp_sat;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= S_CLEAR;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    ram_we     = 1'b0;
    ram_addr   = wptr_reg;
    ram_wdata  = x_reg;
    case (state_reg)
      S_CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_ptr_reg;
        ram_wdata = '0;
        if (clr_ptr_reg == SH'(DEPTH - 1)) state_next = S_IDLE;
      end
      S_IDLE:   if (sample_tick_i) state_next = S_READ;
      S_READ:   state_next = S_UPDATE;
      S_UPDATE: begin
        ram_we     = 1'b1;
        state_next = S_OUT;
      end
      S_OUT:    state_next = S_IDLE;
      default:  state_next = S_CLEAR;
    endcase
  end

  // Read-first single-port RAM; the slot at wptr holds the sample leaving the window.
  always_ff @(posedge clk_i) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_q_reg <= mem[ram_addr];
  end

  assign acc_next = acc_reg + {{SH{x_reg[DWIDTH-1]}}, x_reg}
                            - {{SH{ram_q_reg[DWIDTH-1]}}, ram_q_reg};

  // Dropping the low SH bits of the sum is an arithmetic shift, i.e. floor division.
  assign mean = acc_reg[AW-1:SH];
  assign hp   = {x_reg[DWIDTH-1], x_reg} - {mean[DWIDTH-1], mean};

  always_comb begin
    hp_sat = hp[DWIDTH-1:0];
    if (hp[DWIDTH] != hp[DWIDTH-1])
      hp_sat = hp[DWIDTH] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clr_ptr_reg <= '0;
      wptr_reg    <= '0;
      acc_reg     <= '0;
      x_reg       <= '0;
      sat_reg     <= '0;
      data_reg    <= '0;
      pend_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      ready_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      pend_reg  <= 1'b0;
      valid_reg <= pend_reg;
      if (pend_reg) data_reg <= sat_reg;
      case (state_reg)
        S_CLEAR: begin
          clr_ptr_reg <= clr_ptr_reg + SH'(1);
          if (clr_ptr_reg == SH'(DEPTH - 1)) ready_reg <= 1'b1;
        end
        S_IDLE: if (sample_tick_i) x_reg <= data_i;
        S_READ: if (sample_tick_i) overrun_reg <= 1'b1;
        S_UPDATE: begin
          acc_reg  <= acc_next;
          wptr_reg <= wptr_reg + SH'(1);
          if (sample_tick_i) overrun_reg <= 1'b1;
        end
        S_OUT: begin
          // Output stage: valid_o lands four clocks after the sampling edge.
          sat_reg  <= hp_sat;
          pend_reg <= 1'b1;
          if (sample_tick_i) overrun_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign data_o    = enable_i ? data_reg : data_i;
  assign valid_o   = valid_reg;
  assign ready_o   = ready_reg;
  assign overrun_o = overrun_reg;

endmodule
